// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the sequential adder/subtractor:
//   state_t      - control FSM states (IDLE, CALC, DONE)
//   MODE_ADD/SUB - encoding of the mode input
//   add_overflow - signed-overflow rule for a two-operand add with carry-in
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Signed overflow of x + y (+carry): operands agree in sign, result does not.
  function automatic logic add_overflow(input logic x_msb, input logic y_msb,
                                        input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// CHUNK-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  [CHUNK-1:0] in  - chunk operands
//   cin               in  - carry into bit 0
//   sum   [CHUNK-1:0] out - chunk sum
//   cout              out - carry out of the top bit
// -----------------------------------------------------------------------------
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[CHUNK];

endmodule

// File: rtl/seq_addsub.sv
// -----------------------------------------------------------------------------
// seq_addsub
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a single
// shared addsub_chunk, ripple-style from the least significant chunk upward.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only in IDLE)
//   mode                - 0 add, 1 subtract (sampled on accept)
//   a, b  [WIDTH-1:0]   - operands (sampled on accept)
//   cin                 - carry-in / borrow-in (sampled on accept)
//   out_valid/out_ready - result handshake (valid only in DONE)
//   sum   [WIDTH-1:0]   - result
//   carry, overflow, zero - raw carry-out, signed overflow, sum == 0
// -----------------------------------------------------------------------------
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_addsub: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;        // already inverted for subtract
  logic             run_c_r;    // carry between chunks
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] sum_chunk_s;
  logic             cout_s;
  logic [WIDTH-1:0] next_sum_s;
  logic             last_s;

  // Slice out the chunk being worked on and form the updated sum word.
  always_comb begin
    a_chunk_s  = a_r[int'(idx_r) * CHUNK +: CHUNK];
    b_chunk_s  = b_r[int'(idx_r) * CHUNK +: CHUNK];
    next_sum_s = sum_r;
    next_sum_s[int'(idx_r) * CHUNK +: CHUNK] = sum_chunk_s;
    last_s     = (idx_r == LAST_IDX);
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (run_c_r),
    .sum  (sum_chunk_s),
    .cout (cout_s)
  );

  // Control FSM, operand capture, chunk iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      run_c_r     <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            // Subtract is a + ~b + ~borrow, so the inversion happens once here.
            b_r        <= (mode == MODE_SUB) ? ~b : b;
            run_c_r    <= (mode == MODE_SUB) ? ~cin : cin;
            idx_r      <= {IDXW{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end
        end
        CALC: begin
          sum_r   <= next_sum_s;
          run_c_r <= cout_s;
          idx_r   <= idx_r + 1'b1;
          if (last_s) begin
            carry_r     <= cout_s;
            overflow_r  <= add_overflow(a_r[WIDTH-1], b_r[WIDTH-1],
                                        next_sum_s[WIDTH-1]);
            zero_r      <= (next_sum_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so a retire never overlaps an accept.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign carry     = carry_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_seq_addsub.sv
// -----------------------------------------------------------------------------
// tb_seq_addsub
// Three instances (CHUNK = 8, 32, 1) share operand inputs and reset. Expected
// results come from a plain-arithmetic model and are queued at accept; a
// negedge monitor pops and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
module tb_seq_addsub;

  localparam int W  = 32;
  localparam int NI = 3;

  function automatic int chunk_of(input int g);
    case (g)
      0:       return 8;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    int           g;
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] out_ready = '0;
  logic          mode = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;

  wire [NI-1:0]  in_ready;
  wire [NI-1:0]  out_valid;
  wire [NI-1:0]  carry;
  wire [NI-1:0]  overflow;
  wire [NI-1:0]  zero;
  wire [W-1:0]   sum_w [NI];

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_addsub #(.WIDTH(W), .CHUNK(chunk_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_w[g]),
      .carry     (carry[g]),
      .overflow  (overflow[g]),
      .zero      (zero[g])
    );
  end

  // Reference: full-precision integer arithmetic on the original operands.
  function automatic exp_t model(input int g, input logic m, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic ci);
    exp_t   e;
    longint ua, ub, ur, sa, sb, sr, c;
    ua = longint'({32'd0, av});
    ub = longint'({32'd0, bv});
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    c  = ci ? 64'sd1 : 64'sd0;
    if (m) begin
      ur  = ua - ub - c;
      sr  = sa - sb - c;
      e.c = (ur >= 64'sd0);
    end else begin
      ur  = ua + ub + c;
      sr  = sa + sb + c;
      e.c = (ur > 64'sd4294967295);
    end
    e.g   = g;
    e.sum = ur[31:0];
    e.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z   = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic check(input string nm, input int g, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h, required %0h", nm, g, act, req);
    end
  endtask

  // Scoreboard monitor: compare every handed-over result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < NI; g++) begin
      if (!rst && out_valid[g] && out_ready[g]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result inst%0d: got sum %0h, required no result", g, sum_w[g]);
        end else begin
          e = exp_q.pop_front();
          check("result_inst", g, 64'(g), 64'(e.g));
          check("sum", g, 64'(sum_w[g]), 64'(e.sum));
          check("carry", g, 64'(carry[g]), 64'(e.c));
          check("overflow", g, 64'(overflow[g]), 64'(e.o));
          check("zero", g, 64'(zero[g]), 64'(e.z));
        end
      end
    end
  end

  task automatic issue(input int g, input logic m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ci);
    int t = 0;
    while (in_ready[g] !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_before_issue", g, 64'(in_ready[g]), 64'd1);
    mode = m; a = av; b = bv; cin = ci;
    in_valid[g] = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(g, m, av, bv, ci));
    #1;
    in_valid[g] = 1'b0;
    mode = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
  endtask

  // Counts cycles from the accepting edge to out_valid while scrambling inputs.
  task automatic await_done(input int g);
    int n = 0;
    while (out_valid[g] !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      a = $urandom; b = $urandom; mode = 1'($urandom); cin = 1'($urandom);
      in_valid[g] = 1'($urandom);
    end
    in_valid[g] = 1'b0;
    check("latency", g, 64'(n), 64'(W / chunk_of(g)));
  endtask

  task automatic retire(input int g);
    int t = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    out_ready[g] = 1'b1;
    in_valid[g]  = 1'b1;   // must not be taken on the retiring edge
    while (out_valid[g] === 1'b1 && t < 10) begin
      @(posedge clk); #1; t++;
    end
    check("out_valid_after_retire", g, 64'(out_valid[g]), 64'd0);
    check("in_ready_after_retire", g, 64'(in_ready[g]), 64'd1);
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
  endtask

  task automatic op(input int g, input logic m, input logic [W-1:0] av,
                    input logic [W-1:0] bv, input logic ci);
    issue(g, m, av, bv, ci);
    await_done(g);
    retire(g);
  endtask

  task automatic check_reset_state(input int g);
    check("rst_in_ready", g, 64'(in_ready[g]), 64'd1);
    check("rst_out_valid", g, 64'(out_valid[g]), 64'd0);
    check("rst_sum", g, 64'(sum_w[g]), 64'd0);
    check("rst_carry", g, 64'(carry[g]), 64'd0);
    check("rst_overflow", g, 64'(overflow[g]), 64'd0);
    check("rst_zero", g, 64'(zero[g]), 64'd0);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) check_reset_state(g);
    rst = 1'b0;

    for (int g = 0; g < NI; g++) begin
      // directed boundary vectors
      op(g, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      op(g, 1'b1, 32'd100, 32'd20, 1'b0);
      op(g, 1'b1, 32'd20, 32'd100, 1'b0);
      op(g, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      op(g, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
      op(g, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
      op(g, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      op(g, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
      // randomized traffic, some operands forced to extreme values
      for (int i = 0; i < 25; i++) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 3) == 0) ra = {ra[31], {31{~ra[31]}}};
        if ($urandom_range(0, 3) == 0) rb = ra;
        op(g, 1'($urandom), ra, rb, 1'($urandom));
      end
    end

    // Hold in DONE with out_ready low while new operands are offered.
    for (int g = 0; g < NI; g++) begin
      issue(g, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      e = model(g, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      await_done(g);
      for (int k = 0; k < 5; k++) begin
        in_valid[g] = 1'b1;
        a = $urandom; b = $urandom; mode = 1'($urandom); cin = 1'($urandom);
        @(posedge clk); #1;
        check("hold_sum", g, 64'(sum_w[g]), 64'(e.sum));
        check("hold_carry", g, 64'(carry[g]), 64'(e.c));
        check("hold_overflow", g, 64'(overflow[g]), 64'(e.o));
        check("hold_zero", g, 64'(zero[g]), 64'(e.z));
        check("hold_in_ready", g, 64'(in_ready[g]), 64'd0);
        check("hold_out_valid", g, 64'(out_valid[g]), 64'd1);
      end
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      @(posedge clk); #1;
      out_ready[g] = 1'b0;
      check("release_out_valid", g, 64'(out_valid[g]), 64'd0);
      check("release_in_ready", g, 64'(in_ready[g]), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("no_late_accept", g, 64'(out_valid[g]), 64'd0);
    end

    // Reset in the second CALC cycle aborts the operation.
    for (int g = 0; g < NI; g += 2) begin
      issue(g, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check_reset_state(g);
      op(g, 1'b1, 32'd100, 32'd20, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("pending_results", 0, 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
